// File: rtl/sensor_scan_controller_pkg.sv
// sensor_scan_controller_pkg: shared state encoding and defaults for the sensor scanner
package sensor_scan_controller_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, SETTLE} state_t;
  localparam logic [3:0] TRIG_TICKS_DEF = 4'd10;
  localparam logic [3:0] SETTLE_TICKS_DEF = 4'd15;
  localparam int ECHO_W_DEF = 16;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sensor_scan_controller_if.sv
// sensor_scan_controller_if: timer handshake, sensor lines and sample output bundle
interface sensor_scan_controller_if #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W = 2,
  parameter int ECHO_W = 16
);
  logic scan_en;
  logic start_timer;
  logic [3:0] timer_value;
  logic timer_tick;
  logic time_expired;
  logic [NUM_SENSORS-1:0] trig;
  logic [NUM_SENSORS-1:0] echo;
  logic sample_valid;
  logic [SEL_W-1:0] sample_id;
  logic [ECHO_W-1:0] sample_width;
  logic sample_timeout;
  modport master (
    input scan_en, time_expired, echo,
    output start_timer, timer_value, timer_tick, trig,
    output sample_valid, sample_id, sample_width, sample_timeout
  );
  modport slave (
    output scan_en, time_expired, echo,
    input start_timer, timer_value, timer_tick, trig,
    input sample_valid, sample_id, sample_width, sample_timeout
  );
endinterface

// File: rtl/sensor_scan_controller_tick_prescaler.sv
// tick_prescaler: free-running divider, one-cycle tick every TICK_DIV clocks
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end
  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/sensor_scan_controller.sv
// sensor_scan_controller: round-robin ultrasonic scanner driving an external delay timer
// Define ECHO_SYNC_EN to pass echo lines through a 2-flop synchroniser.
module sensor_scan_controller
  import sensor_scan_controller_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int TICK_DIV = 100,
  parameter logic [3:0] TRIG_TICKS = TRIG_TICKS_DEF,
  parameter logic [3:0] SETTLE_TICKS = SETTLE_TICKS_DEF,
  parameter int ECHO_W = ECHO_W_DEF,
  parameter int ECHO_TIMEOUT = 30000,
  localparam int SEL_W = sel_w(NUM_SENSORS)
) (
  input logic clk,
  input logic reset,
  sensor_scan_controller_if.master bus
);
  localparam logic [NUM_SENSORS-1:0] ONE = NUM_SENSORS'(1);
  localparam logic [ECHO_W-1:0] TIMEOUT_W = ECHO_W'(ECHO_TIMEOUT);
  localparam logic [ECHO_W-1:0] W1 = ECHO_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SENSORS - 1);
  state_t state_q;
  logic [SEL_W-1:0] sel_q, sid_q;
  logic [NUM_SENSORS-1:0] trig_q, echo_s;
  logic [ECHO_W-1:0] wait_q, width_q, sw_q;
  logic [3:0] tval_q;
  logic start_q, prev_q, sv_q, sto_q;
  logic echo_cur, rise, wait_done, meas_fall, meas_sat, emit, emit_to;
  logic [ECHO_W-1:0] emit_w;
  logic [SEL_W-1:0] sel_nx;
`ifdef ECHO_SYNC_EN
  logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.echo;
      sync2_q <= sync1_q;
    end
  end
  assign echo_s = sync2_q;
`else
  assign echo_s = bus.echo;
`endif
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk(clk),
    .reset(reset),
    .tick(bus.timer_tick)
  );
  always_comb begin
    echo_cur = echo_s[sel_q];
    rise = echo_cur & ~prev_q;
    wait_done = (state_q == WAIT_ECHO) && !rise && (wait_q >= TIMEOUT_W - W1);
    meas_fall = (state_q == MEASURE) && !echo_cur;
    meas_sat = (state_q == MEASURE) && echo_cur && (width_q >= TIMEOUT_W - W1);
    emit = wait_done | meas_fall | meas_sat;
    emit_w = meas_sat ? TIMEOUT_W : meas_fall ? width_q : '0;
    emit_to = !meas_fall || (width_q >= TIMEOUT_W);
    sel_nx = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      trig_q <= '0;
      wait_q <= '0;
      width_q <= '0;
      tval_q <= '0;
      start_q <= 1'b0;
      prev_q <= 1'b0;
      sv_q <= 1'b0;
      sid_q <= '0;
      sw_q <= '0;
      sto_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      sv_q <= 1'b0;
      prev_q <= echo_cur;
      if (emit) begin
        state_q <= SETTLE;
        start_q <= 1'b1;
        tval_q <= SETTLE_TICKS;
        sv_q <= 1'b1;
        sid_q <= sel_q;
        sw_q <= emit_w;
        sto_q <= emit_to;
      end else begin
        case (state_q)
          IDLE: if (bus.scan_en) begin
            state_q <= TRIG;
            start_q <= 1'b1;
            tval_q <= TRIG_TICKS;
            trig_q <= ONE << sel_q;
          end
          TRIG: if (bus.time_expired) begin
            state_q <= WAIT_ECHO;
            trig_q <= '0;
            wait_q <= '0;
            // an echo already high on entry must go low before it counts as a rise
            prev_q <= 1'b1;
          end
          WAIT_ECHO: if (rise) begin
            state_q <= MEASURE;
            width_q <= W1;
          end else wait_q <= wait_q + W1;
          MEASURE: width_q <= width_q + W1;
          SETTLE: if (bus.time_expired) begin
            sel_q <= sel_nx;
            state_q <= bus.scan_en ? TRIG : IDLE;
            if (bus.scan_en) begin
              start_q <= 1'b1;
              tval_q <= TRIG_TICKS;
              trig_q <= ONE << sel_nx;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.start_timer = start_q;
  assign bus.timer_value = tval_q;
  assign bus.trig = trig_q;
  assign bus.sample_valid = sv_q;
  assign bus.sample_id = sid_q;
  assign bus.sample_width = sw_q;
  assign bus.sample_timeout = sto_q;
endmodule
